// File: rtl/adpll_pkg.sv
// Shared definitions for the ADPLL lock controller.
//   state_e  : lock-controller state encoding (also driven out on state_o)
//   STATE_W  : width of the encoded state output
//   cnt_width: bits needed to hold a counter value 0..n
package adpll_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET_HOLD = 2'd0,
        ST_ACQUIRE    = 2'd1,
        ST_TRACK      = 2'd2,
        ST_LOCKED     = 2'd3
    } state_e;

    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser followed by a history flop, producing a one-cycle
// pulse on each rising edge of an asynchronous input.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset
//   d_i    : asynchronous input
//   rise_o : one-cycle pulse on a synchronised rising edge
module sync_edge_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic hist_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign rise_o = sync2_q & ~hist_q;

endmodule

// File: rtl/adpll_lock_ctrl.sv
// ADPLL lock controller: sequences oscillator reset, acquisition gain,
// tracking gain and lock detection from phase-error samples taken on each
// reference-clock rising edge.
//
// Ports:
//   fpga_clk_i  : system clock
//   reset_n_i   : asynchronous active-low reset (release synchronised inside)
//   enable_i    : run request; low forces RESET_HOLD
//   ref_clk_i   : asynchronous reference clock, rising edge = new sample
//   error_i     : signed phase error
//   ro_reset_o  : reset to oscillator / divider / phase detector / loop filter
//   kp_sel_o    : proportional gain select (1 = acquisition gain)
//   ki_sel_o    : integral gain select (1 = acquisition gain)
//   locked_o    : high while LOCKED
//   lock_lost_o : one-cycle pulse on every exit from LOCKED
//   state_o     : encoded state
//   acq_fail_o  : sticky acquisition timeout flag (only with
//                 ADPLL_LOCK_CTRL_TIMEOUT_EN defined)
//
// State table:
//   state      | meaning
//   RESET_HOLD | oscillator held in reset for RESET_CYCLES, acquisition gains
//   ACQUIRE    | loop running on acquisition gains, waiting for small error
//   TRACK      | tracking gains, counting consecutive in-lock samples
//   LOCKED     | lock declared, counting consecutive out-of-lock samples
module adpll_lock_ctrl
    import adpll_pkg::*;
#(
    parameter int ERROR_WIDTH    = 8,
    parameter int ACQ_THRESH     = 8,
    parameter int LOCK_THRESH    = 2,
    parameter int LOCK_COUNT     = 16,
    parameter int UNLOCK_THRESH  = 8,
    parameter int UNLOCK_COUNT   = 4,
    parameter int RESET_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                   fpga_clk_i,
    input  logic                   reset_n_i,
    input  logic                   enable_i,
    input  logic                   ref_clk_i,
    input  logic [ERROR_WIDTH-1:0] error_i,
    output logic                   ro_reset_o,
    output logic                   kp_sel_o,
    output logic                   ki_sel_o,
    output logic                   locked_o,
    output logic                   lock_lost_o,
    output logic [STATE_W-1:0]     state_o
`ifdef ADPLL_LOCK_CTRL_TIMEOUT_EN
    ,
    output logic                   acq_fail_o
`endif
);

    localparam int LOCK_W   = cnt_width(LOCK_COUNT);
    localparam int UNLOCK_W = cnt_width(UNLOCK_COUNT);
`ifdef ADPLL_LOCK_CTRL_TIMEOUT_EN
    localparam int CYC_MAX  = (TIMEOUT_CYCLES > RESET_CYCLES) ? TIMEOUT_CYCLES : RESET_CYCLES;
`else
    localparam int CYC_MAX  = RESET_CYCLES;
`endif
    localparam int CYC_W    = cnt_width(CYC_MAX);

    localparam logic [CYC_W-1:0]       RST_LAST    = CYC_W'(RESET_CYCLES - 1);
`ifdef ADPLL_LOCK_CTRL_TIMEOUT_EN
    localparam logic [CYC_W-1:0]       TMO_LAST    = CYC_W'(TIMEOUT_CYCLES - 1);
`endif
    localparam logic [LOCK_W-1:0]      LOCK_LAST   = LOCK_W'(LOCK_COUNT - 1);
    localparam logic [UNLOCK_W-1:0]    UNLOCK_LAST = UNLOCK_W'(UNLOCK_COUNT - 1);

    localparam logic [ERROR_WIDTH-1:0] ACQ_T    = ERROR_WIDTH'(ACQ_THRESH);
    localparam logic [ERROR_WIDTH-1:0] LOCK_T   = ERROR_WIDTH'(LOCK_THRESH);
    localparam logic [ERROR_WIDTH-1:0] UNLOCK_T = ERROR_WIDTH'(UNLOCK_THRESH);
    localparam logic [ERROR_WIDTH-1:0] ERR_MIN  = {1'b1, {(ERROR_WIDTH-1){1'b0}}};
    localparam logic [ERROR_WIDTH-1:0] ERR_MAX  = {1'b0, {(ERROR_WIDTH-1){1'b1}}};

    // Reset: asserts asynchronously, releases two clocks after reset_n_i rises.
    logic rst_meta_q;
    logic rst_sync_q;
    logic rst_n;

    always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    assign rst_n = rst_sync_q;

    logic strobe;

    sync_edge_det u_ref_edge (
        .clk_i  (fpga_clk_i),
        .rst_ni (rst_n),
        .d_i    (ref_clk_i),
        .rise_o (strobe)
    );

    state_e                 state_q,      state_d;
    logic [CYC_W-1:0]       cyc_cnt_q,    cyc_cnt_d;
    logic [LOCK_W-1:0]      lock_cnt_q,   lock_cnt_d;
    logic [UNLOCK_W-1:0]    unlock_cnt_q, unlock_cnt_d;
    logic [ERROR_WIDTH-1:0] err_abs_q,    err_abs_d;
    logic                   sample_vld_q, sample_vld_d;
    logic                   ro_reset_q,   ro_reset_d;
    logic                   kp_sel_q,     kp_sel_d;
    logic                   ki_sel_q,     ki_sel_d;
    logic                   locked_q,     locked_d;
    logic                   lock_lost_q,  lock_lost_d;
`ifdef ADPLL_LOCK_CTRL_TIMEOUT_EN
    logic                   acq_fail_q,   acq_fail_d;
`endif

    logic err_le_acq;
    logic err_le_lock;
    logic err_gt_unlock;

    // Sample capture: the most negative code has no positive twin, so it
    // saturates to the largest positive magnitude.
    always_comb begin
        err_abs_d    = err_abs_q;
        sample_vld_d = strobe;
        if (strobe) begin
            if (error_i == ERR_MIN) begin
                err_abs_d = ERR_MAX;
            end else if (error_i[ERROR_WIDTH-1]) begin
                err_abs_d = ~error_i + 1'b1;
            end else begin
                err_abs_d = error_i;
            end
        end
    end

    assign err_le_acq    = (err_abs_q <= ACQ_T);
    assign err_le_lock   = (err_abs_q <= LOCK_T);
    assign err_gt_unlock = (err_abs_q > UNLOCK_T);

    always_comb begin
        state_d      = state_q;
        cyc_cnt_d    = cyc_cnt_q;
        lock_cnt_d   = lock_cnt_q;
        unlock_cnt_d = unlock_cnt_q;
        lock_lost_d  = 1'b0;
`ifdef ADPLL_LOCK_CTRL_TIMEOUT_EN
        acq_fail_d   = acq_fail_q;
`endif

        if (!enable_i) begin
            state_d   = ST_RESET_HOLD;
            cyc_cnt_d = '0;
            if (state_q == ST_LOCKED) begin
                lock_lost_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                ST_RESET_HOLD: begin
                    if (cyc_cnt_q >= RST_LAST) begin
                        state_d = ST_ACQUIRE;
                    end else begin
                        cyc_cnt_d = cyc_cnt_q + 1'b1;
                    end
                end
                ST_ACQUIRE: begin
                    if (sample_vld_q && err_le_acq) begin
                        state_d = ST_TRACK;
`ifdef ADPLL_LOCK_CTRL_TIMEOUT_EN
                    end else if (cyc_cnt_q >= TMO_LAST) begin
                        state_d    = ST_RESET_HOLD;
                        acq_fail_d = 1'b1;
                    end else begin
                        cyc_cnt_d = cyc_cnt_q + 1'b1;
`endif
                    end
                end
                ST_TRACK: begin
                    if (sample_vld_q) begin
                        if (err_gt_unlock) begin
                            state_d = ST_ACQUIRE;
                        end else if (err_le_lock) begin
                            if (lock_cnt_q >= LOCK_LAST) begin
                                state_d = ST_LOCKED;
                            end else begin
                                lock_cnt_d = lock_cnt_q + 1'b1;
                            end
                        end else begin
                            lock_cnt_d = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (sample_vld_q) begin
                        if (err_gt_unlock) begin
                            if (unlock_cnt_q >= UNLOCK_LAST) begin
                                state_d     = ST_ACQUIRE;
                                lock_lost_d = 1'b1;
                            end else begin
                                unlock_cnt_d = unlock_cnt_q + 1'b1;
                            end
                        end else begin
                            unlock_cnt_d = '0;
                        end
                    end
                end
                default: begin
                    state_d = ST_RESET_HOLD;
                end
            endcase
        end

        // Every transition starts the next state with fresh counters.
        if (state_d != state_q) begin
            cyc_cnt_d    = '0;
            lock_cnt_d   = '0;
            unlock_cnt_d = '0;
        end

`ifdef ADPLL_LOCK_CTRL_TIMEOUT_EN
        if (state_d == ST_LOCKED) begin
            acq_fail_d = 1'b0;
        end
`endif

        // Outputs decoded from the next state so they change with it.
        ro_reset_d = (state_d == ST_RESET_HOLD);
        kp_sel_d   = (state_d == ST_RESET_HOLD) || (state_d == ST_ACQUIRE);
        ki_sel_d   = (state_d == ST_RESET_HOLD) || (state_d == ST_ACQUIRE);
        locked_d   = (state_d == ST_LOCKED);
    end

    always_ff @(posedge fpga_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RESET_HOLD;
            cyc_cnt_q    <= '0;
            lock_cnt_q   <= '0;
            unlock_cnt_q <= '0;
            err_abs_q    <= '0;
            sample_vld_q <= 1'b0;
            ro_reset_q   <= 1'b1;
            kp_sel_q     <= 1'b1;
            ki_sel_q     <= 1'b1;
            locked_q     <= 1'b0;
            lock_lost_q  <= 1'b0;
`ifdef ADPLL_LOCK_CTRL_TIMEOUT_EN
            acq_fail_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cyc_cnt_q    <= cyc_cnt_d;
            lock_cnt_q   <= lock_cnt_d;
            unlock_cnt_q <= unlock_cnt_d;
            err_abs_q    <= err_abs_d;
            sample_vld_q <= sample_vld_d;
            ro_reset_q   <= ro_reset_d;
            kp_sel_q     <= kp_sel_d;
            ki_sel_q     <= ki_sel_d;
            locked_q     <= locked_d;
            lock_lost_q  <= lock_lost_d;
`ifdef ADPLL_LOCK_CTRL_TIMEOUT_EN
            acq_fail_q   <= acq_fail_d;
`endif
        end
    end

    assign ro_reset_o  = ro_reset_q;
    assign kp_sel_o    = kp_sel_q;
    assign ki_sel_o    = ki_sel_q;
    assign locked_o    = locked_q;
    assign lock_lost_o = lock_lost_q;
    assign state_o     = state_q;
`ifdef ADPLL_LOCK_CTRL_TIMEOUT_EN
    assign acq_fail_o  = acq_fail_q;
`endif

endmodule

// File: tb/tb_adpll_lock_ctrl.sv
// Testbench for adpll_lock_ctrl (default parameters; the timeout scenario
// is built only with ADPLL_LOCK_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=100).
module tb_adpll_lock_ctrl;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic       ref_clk;
    logic [7:0] error;
    logic       ro_reset_o;
    logic       kp_sel_o;
    logic       ki_sel_o;
    logic       locked_o;
    logic       lock_lost_o;
    logic [1:0] state_o;
`ifdef ADPLL_LOCK_CTRL_TIMEOUT_EN
    logic       acq_fail_o;
`endif

    adpll_lock_ctrl #(
        .ERROR_WIDTH(8)
`ifdef ADPLL_LOCK_CTRL_TIMEOUT_EN
        , .TIMEOUT_CYCLES(100)
`endif
    ) dut (
        .fpga_clk_i  (clk),
        .reset_n_i   (reset_n),
        .enable_i    (enable),
        .ref_clk_i   (ref_clk),
        .error_i     (error),
        .ro_reset_o  (ro_reset_o),
        .kp_sel_o    (kp_sel_o),
        .ki_sel_o    (ki_sel_o),
        .locked_o    (locked_o),
        .lock_lost_o (lock_lost_o),
        .state_o     (state_o)
`ifdef ADPLL_LOCK_CTRL_TIMEOUT_EN
        , .acq_fail_o (acq_fail_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int lost_seen = 0;

    always @(negedge clk) begin
        if (lock_lost_o === 1'b1) lost_seen++;
    end

    // Sample-level reference model of the controller.
    int m_state = 0;
    int m_lock  = 0;
    int m_unl   = 0;
    int m_lost  = 0;

    typedef struct {
        logic [1:0] st;
        logic       lk;
        int         lost;
    } exp_t;
    exp_t exp_q[$];

    task automatic model_step(input int e);
        int a;
        int nxt;
        a = (e < 0) ? -e : e;
        if (a > 127) a = 127;
        nxt = m_state;
        case (m_state)
            1: if (a <= 8) nxt = 2;
            2: begin
                if (a > 8) nxt = 1;
                else if (a <= 2) begin
                    m_lock++;
                    if (m_lock >= 16) nxt = 3;
                end else m_lock = 0;
            end
            3: begin
                if (a > 8) begin
                    m_unl++;
                    if (m_unl >= 4) begin
                        nxt = 1;
                        m_lost++;
                    end
                end else m_unl = 0;
            end
            default: ;
        endcase
        if (nxt != m_state) begin
            m_lock = 0;
            m_unl  = 0;
        end
        m_state = nxt;
    endtask

    // Drives one reference edge carrying error e and queues the expectation.
    task automatic drive_sample(input int e);
        exp_t x;
        model_step(e);
        x.st   = 2'(m_state);
        x.lk   = (m_state == 3);
        x.lost = m_lost;
        exp_q.push_back(x);
        error   = 8'(e);
        ref_clk = 1'b1;
        repeat (5) @(negedge clk);
        ref_clk = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        enable  = 1'b0;
        ref_clk = 1'b0;
        error   = 8'd0;
        repeat (3) @(negedge clk);
        n_cmp += 6;
        if (ro_reset_o !== 1'b1) begin n_err++; $display("FAIL reset_ro_reset got %b want 1", ro_reset_o); end
        if (kp_sel_o !== 1'b1) begin n_err++; $display("FAIL reset_kp_sel got %b want 1", kp_sel_o); end
        if (ki_sel_o !== 1'b1) begin n_err++; $display("FAIL reset_ki_sel got %b want 1", ki_sel_o); end
        if (locked_o !== 1'b0) begin n_err++; $display("FAIL reset_locked got %b want 0", locked_o); end
        if (lock_lost_o !== 1'b0) begin n_err++; $display("FAIL reset_lock_lost got %b want 0", lock_lost_o); end
        if (state_o !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", state_o); end
`ifdef ADPLL_LOCK_CTRL_TIMEOUT_EN
        n_cmp++;
        if (acq_fail_o !== 1'b0) begin n_err++; $display("FAIL reset_acq_fail got %b want 0", acq_fail_o); end
`endif
    endtask

    // Release reset, hold disabled for a while, then count the hold period.
    task automatic test_reset_hold;
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        n_cmp++;
        if (state_o !== 2'd0) begin n_err++; $display("FAIL hold_disabled_state got %0d want 0", state_o); end
        enable = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            n_cmp += 2;
            if (state_o !== ((k < 16) ? 2'd0 : 2'd1)) begin
                n_err++; $display("FAIL hold_state cycle %0d got %0d want %0d", k, state_o, (k < 16) ? 0 : 1);
            end
            if (ro_reset_o !== ((k < 16) ? 1'b1 : 1'b0)) begin
                n_err++; $display("FAIL hold_ro_reset cycle %0d got %b want %b", k, ro_reset_o, (k < 16));
            end
        end
        n_cmp += 2;
        if (kp_sel_o !== 1'b1) begin n_err++; $display("FAIL acquire_kp_sel got %b want 1", kp_sel_o); end
        if (ki_sel_o !== 1'b1) begin n_err++; $display("FAIL acquire_ki_sel got %b want 1", ki_sel_o); end
        m_state = 1;
        m_lock  = 0;
        m_unl   = 0;
    endtask

    task automatic test_acquire;
        int errs[$] = '{9, -5};
        exp_t x;
        foreach (errs[i]) begin
            drive_sample(errs[i]);
            x = exp_q.pop_front();
            n_cmp += 2;
            if (state_o !== x.st) begin n_err++; $display("FAIL acquire_state err %0d got %0d want %0d", errs[i], state_o, x.st); end
            if (kp_sel_o !== (x.st < 2)) begin n_err++; $display("FAIL acquire_gain err %0d got %b want %b", errs[i], kp_sel_o, (x.st < 2)); end
        end
    endtask

    task automatic test_lock;
        exp_t x;
        for (int i = 0; i < 16; i++) begin
            drive_sample((i % 5) - 2);
            x = exp_q.pop_front();
            n_cmp += 2;
            if (state_o !== x.st) begin n_err++; $display("FAIL lock_state sample %0d got %0d want %0d", i, state_o, x.st); end
            if (locked_o !== x.lk) begin n_err++; $display("FAIL lock_locked sample %0d got %b want %b", i, locked_o, x.lk); end
        end
    endtask

    task automatic test_unlock;
        int errs[$] = '{9, 9, 9, 0, -128, -128, -128, -128};
        exp_t x;
        foreach (errs[i]) begin
            drive_sample(errs[i]);
            x = exp_q.pop_front();
            n_cmp += 3;
            if (state_o !== x.st) begin n_err++; $display("FAIL unlock_state sample %0d got %0d want %0d", i, state_o, x.st); end
            if (locked_o !== x.lk) begin n_err++; $display("FAIL unlock_locked sample %0d got %b want %b", i, locked_o, x.lk); end
            if (lost_seen !== x.lost) begin n_err++; $display("FAIL unlock_pulses sample %0d got %0d want %0d", i, lost_seen, x.lost); end
        end
    endtask

    task automatic test_track_boundaries;
        int errs[$] = '{8, 8, 9, -8};
        exp_t x;
        foreach (errs[i]) begin
            drive_sample(errs[i]);
            x = exp_q.pop_front();
            n_cmp++;
            if (state_o !== x.st) begin n_err++; $display("FAIL bound_state err %0d got %0d want %0d", errs[i], state_o, x.st); end
        end
    endtask

    task automatic test_relock_glitch;
        exp_t x;
        int e;
        for (int i = 0; i < 26; i++) begin
            e = (i == 9) ? 3 : ((i % 5) - 2);
            drive_sample(e);
            x = exp_q.pop_front();
            n_cmp += 2;
            if (state_o !== x.st) begin n_err++; $display("FAIL glitch_state sample %0d got %0d want %0d", i, state_o, x.st); end
            if (locked_o !== x.lk) begin n_err++; $display("FAIL glitch_locked sample %0d got %b want %b", i, locked_o, x.lk); end
        end
    endtask

    task automatic test_enable_drop;
        enable = 1'b0;
        @(negedge clk);
        n_cmp += 4;
        if (lock_lost_o !== 1'b1) begin n_err++; $display("FAIL drop_pulse got %b want 1", lock_lost_o); end
        if (ro_reset_o !== 1'b1) begin n_err++; $display("FAIL drop_ro_reset got %b want 1", ro_reset_o); end
        if (state_o !== 2'd0) begin n_err++; $display("FAIL drop_state got %0d want 0", state_o); end
        if (locked_o !== 1'b0) begin n_err++; $display("FAIL drop_locked got %b want 0", locked_o); end
        @(negedge clk);
        m_lost++;
        m_state = 0;
        n_cmp += 2;
        if (lock_lost_o !== 1'b0) begin n_err++; $display("FAIL drop_pulse_width got %b want 0", lock_lost_o); end
        if (lost_seen !== m_lost) begin n_err++; $display("FAIL drop_pulse_count got %0d want %0d", lost_seen, m_lost); end
    endtask

    task automatic test_async_reset;
        exp_t x;
        enable = 1'b1;
        repeat (16) @(negedge clk);
        m_state = 1;
        n_cmp++;
        if (state_o !== 2'd1) begin n_err++; $display("FAIL rearm_state got %0d want 1", state_o); end
        drive_sample(0);
        x = exp_q.pop_front();
        n_cmp++;
        if (state_o !== x.st) begin n_err++; $display("FAIL rearm_track got %0d want %0d", state_o, x.st); end
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_cmp += 5;
        if (ro_reset_o !== 1'b1) begin n_err++; $display("FAIL areset_ro_reset got %b want 1", ro_reset_o); end
        if (kp_sel_o !== 1'b1) begin n_err++; $display("FAIL areset_kp_sel got %b want 1", kp_sel_o); end
        if (ki_sel_o !== 1'b1) begin n_err++; $display("FAIL areset_ki_sel got %b want 1", ki_sel_o); end
        if (locked_o !== 1'b0 || lock_lost_o !== 1'b0) begin n_err++; $display("FAIL areset_lock got %b/%b want 0/0", locked_o, lock_lost_o); end
        if (state_o !== 2'd0) begin n_err++; $display("FAIL areset_state got %0d want 0", state_o); end
        m_state = 0;
        m_lock  = 0;
        m_unl   = 0;
    endtask

`ifdef ADPLL_LOCK_CTRL_TIMEOUT_EN
    task automatic test_timeout;
        int n;
        enable = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        enable = 1'b1;
        repeat (16) @(negedge clk);
        error = 8'd50;
        n = 0;
        while (state_o === 2'd1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        n_cmp += 3;
        if (n !== 100) begin n_err++; $display("FAIL timeout_cycles got %0d want 100", n); end
        if (state_o !== 2'd0) begin n_err++; $display("FAIL timeout_state got %0d want 0", state_o); end
        if (acq_fail_o !== 1'b1) begin n_err++; $display("FAIL timeout_acq_fail got %b want 1", acq_fail_o); end
    endtask
`endif

    initial begin
        test_reset;
        test_reset_hold;
        test_acquire;
        test_lock;
        test_unlock;
        test_track_boundaries;
        test_relock_glitch;
        test_enable_drop;
        test_async_reset;
`ifdef ADPLL_LOCK_CTRL_TIMEOUT_EN
        test_timeout;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adpll_lock_ctrl.md
ADPLL_LOCK_CTRL -- requirements
Module: adpll_lock_ctrl

Interface
REQ-001 The block SHALL have parameter ERROR_WIDTH, default 8, the signed phase-error width.
REQ-002 The block SHALL have parameter ACQ_THRESH, default 8, the |error| at or below which acquisition hands over to tracking.
REQ-003 The block SHALL have parameter LOCK_THRESH, default 2, the |error| at or below which a sample counts as in-lock.
REQ-004 The block SHALL have parameter LOCK_COUNT, default 16, the consecutive in-lock samples needed to declare lock.
REQ-005 The block SHALL have parameter UNLOCK_THRESH, default 8, the |error| above which a sample counts as out-of-lock.
REQ-006 The block SHALL have parameter UNLOCK_COUNT, default 4, the consecutive out-of-lock samples that drop lock.
REQ-007 The block SHALL have parameter RESET_CYCLES, default 16, the oscillator reset hold length in fpga_clk_i cycles.
REQ-008 The block SHALL have parameter TIMEOUT_CYCLES, default 65535, the acquisition time budget in fpga_clk_i cycles.
REQ-009 fpga_clk_i  in  1  the single system clock; all logic in this domain.
REQ-010 reset_n_i  in  1  reset, asynchronous and active-low.
REQ-011 enable_i  in  1  run request; low forces RESET_HOLD.
REQ-012 ref_clk_i  in  1  reference clock, asynchronous; its rising edge marks a new error sample.
REQ-013 error_i  in  ERROR_WIDTH  signed phase error in fpga_clk_i cycles.
REQ-014 ro_reset_o  out  1  active-high reset to the ring oscillator, divider, phase detector and loop filter.
REQ-015 kp_sel_o, ki_sel_o  out  1 each  loop-filter gain selects; 1 = acquisition gain, 0 = tracking gain.
REQ-016 locked_o  out  1  high only in LOCKED.
REQ-017 lock_lost_o  out  1  one-cycle pulse on each LOCKED exit.
REQ-018 state_o  out  2  encoded state: RESET_HOLD=0, ACQUIRE=1, TRACK=2, LOCKED=3.

Function
REQ-019 ref_clk_i SHALL pass a 2-flop synchroniser plus a third flop; a rising edge on the synchronised signal SHALL give a one-cycle sample strobe 3 cycles after the edge.
REQ-020 On the strobe, error_i SHALL be registered and its absolute value formed, with -2^(ERROR_WIDTH-1) saturating to 2^(ERROR_WIDTH-1)-1; all threshold compares SHALL use this registered value.
REQ-021 RESET_HOLD: ro_reset_o=1, kp_sel_o=ki_sel_o=1; a cycle counter SHALL run while enable_i=1 and, after RESET_CYCLES cycles, go to ACQUIRE with the counter cleared.
REQ-022 ACQUIRE: ro_reset_o=0, kp_sel_o=ki_sel_o=1; on a strobe with |error| <= ACQ_THRESH go to TRACK.
REQ-023 TRACK: kp_sel_o=ki_sel_o=0; count consecutive strobes with |error| <= LOCK_THRESH and clear the count on any other strobe; reaching LOCK_COUNT goes to LOCKED; a strobe with |error| > UNLOCK_THRESH returns to ACQUIRE.
REQ-024 LOCKED: gains 0, locked_o=1; count consecutive strobes with |error| > UNLOCK_THRESH and clear the count on any other strobe; reaching UNLOCK_COUNT goes to ACQUIRE with lock_lost_o pulsed that cycle.
REQ-025 The lock and unlock counters SHALL saturate, and SHALL clear on every state change.
REQ-026 enable_i=0 in any state SHALL go to RESET_HOLD on the next edge; leaving LOCKED this way SHALL also pulse lock_lost_o.
REQ-027 Outputs SHALL be registered and change on the same edge as the state they reflect.

Reset
REQ-028 With reset_n_i low: state RESET_HOLD, ro_reset_o=1, kp_sel_o=ki_sel_o=1, locked_o=0, lock_lost_o=0, state_o=0, all counters and synchroniser flops 0.
REQ-029 Release SHALL be synchronised internally (2-flop, async assert / sync deassert).

Configuration
REQ-030 With ADPLL_LOCK_CTRL_TIMEOUT_EN defined, a counter SHALL run during ACQUIRE; at TIMEOUT_CYCLES it SHALL force RESET_HOLD and set sticky output acq_fail_o (1 bit), which clears only on reset or when LOCKED is reached.
REQ-031 Without ADPLL_LOCK_CTRL_TIMEOUT_EN, ACQUIRE SHALL have no time limit and acq_fail_o SHALL NOT exist.

Structure
REQ-032 The state enum encodings and the state_o width SHALL live in shared package adpll_pkg.
REQ-033 The edge-detecting synchroniser SHALL be sub-module sync_edge_det (2-flop sync + rise pulse), reusable by the phase detector.

Verification
REQ-034 Reset then enable_i=1: ro_reset_o=1 for 16 cycles, then state_o=1, kp_sel_o=ki_sel_o=1.
REQ-035 In ACQUIRE, strobe with error_i=-5: TRACK (state_o=2) and gains 0 one cycle after the strobe.
REQ-036 In TRACK, 16 strobes with error_i in {-2..2}: locked_o=1 after the 16th; the same run with one error_i=3 at sample 10: lock only after 16 more good samples.
REQ-037 In LOCKED, 3 strobes with error_i=9 then one with 0, then 4 with -128: lock_lost_o pulses once after the 4th -128, state_o=1, and -128 is treated as 127.
REQ-038 enable_i dropped in LOCKED: lock_lost_o pulse, ro_reset_o=1 next cycle; reset_n_i asserted mid-TRACK: all outputs at reset values immediately.
REQ-039 With TIMEOUT_EN defined and TIMEOUT_CYCLES=100, error_i held at 50: acq_fail_o=1 and RESET_HOLD at cycle 100 of ACQUIRE.
